// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-control inputs and fetch address/enable outputs of the program counter.
interface pc_gen_if #(parameter int ADDR_W = 32);
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              redirect_pending;
  logic              misaligned;
  modport master (output stall, flush, flush_pc, branch_flag, branch_target,
                  input pc, ce, redirect_pending, misaligned);
  modport slave  (input stall, flush, flush_pc, branch_flag, branch_target,
                  output pc, ce, redirect_pending, misaligned);
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with stall, branch, flush redirect and stall-buffered branches.
module pc_gen #(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int              INST_BYTES   = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HOLD} state_t;
  localparam logic [ADDR_W-1:0] LOW  = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_q, pc_n, pend_q, pend_n;
  logic              ce_q, pending_q, mis_q, mis_n;
  // pending target is stored unaligned so misalignment is judged when it is applied
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    pend_n  = pend_q;
    mis_n   = 1'b0;
    if (state == S_RESET) state_n = S_RUN;
    else if (bus.flush) begin
      pc_n    = bus.flush_pc & ~LOW;
      mis_n   = |(bus.flush_pc & LOW);
      state_n = S_RUN;
    end else if (bus.stall) begin
      pend_n  = bus.branch_flag ? bus.branch_target : pend_q;
      state_n = bus.branch_flag ? S_HOLD : state;
    end else if (bus.branch_flag) begin
      pc_n    = bus.branch_target & ~LOW;
      mis_n   = |(bus.branch_target & LOW);
      state_n = S_RUN;
    end else if (state == S_HOLD) begin
      pc_n    = pend_q & ~LOW;
      mis_n   = |(pend_q & LOW);
      state_n = S_RUN;
    end else pc_n = pc_q + STEP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      pc_q      <= RESET_VECTOR;
      pend_q    <= '0;
      ce_q      <= 1'b0;
      pending_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state     <= state_n;
      pc_q      <= pc_n;
      pend_q    <= pend_n;
      ce_q      <= 1'b1;
      pending_q <= state_n == S_HOLD;
      mis_q     <= mis_n;
    end
  end
  assign bus.pc               = pc_q;
  assign bus.ce               = ce_q;
  assign bus.redirect_pending = pending_q;
  assign bus.misaligned       = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors with a queued scoreboard checked by an independent monitor.
module tb_pc_gen;
  typedef struct {
    int          due;
    string       name;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  pc_gen_if #(.ADDR_W(32)) bus ();
  pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'hBFC00000), .INST_BYTES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.due != cyc || bus.pc !== e.pc || bus.ce !== e.ce ||
          bus.redirect_pending !== e.pend || bus.misaligned !== e.mis) begin
        failures++;
        $display("FAIL %s: got pc=%h ce=%b pend=%b mis=%b, expected pc=%h ce=%b pend=%b mis=%b (due %0d at %0d)",
                 e.name, bus.pc, bus.ce, bus.redirect_pending, bus.misaligned,
                 e.pc, e.ce, e.pend, e.mis, e.due, cyc);
      end
    end
  end
  task automatic step(input string name, input logic r, input logic st, input logic fl,
                      input logic [31:0] fpc, input logic br, input logic [31:0] bt,
                      input logic [31:0] epc, input logic ece, input logic epend, input logic emis);
    exp_t e;
    rst = r;
    bus.stall = st;
    bus.flush = fl;
    bus.flush_pc = fpc;
    bus.branch_flag = br;
    bus.branch_target = bt;
    e.due = cyc + 1;
    e.name = name;
    e.pc = epc;
    e.ce = ece;
    e.pend = epend;
    e.mis = emis;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  localparam logic [31:0] RV = 32'hBFC00000;
  initial begin
    bus.stall = 0; bus.flush = 0; bus.flush_pc = 0; bus.branch_flag = 0; bus.branch_target = 0;
    @(posedge clk);
    #1;
    step("reset0",       1, 0, 0, 0,            0, 0,     RV,           0, 0, 0);
    step("reset1",       1, 0, 1, 32'h40,       1, 32'h80, RV,          0, 0, 0);
    step("release",      0, 1, 1, 32'h40,       1, 32'h80, RV,          1, 0, 0);
    step("run4",         0, 0, 0, 0,            0, 0,     RV + 4,       1, 0, 0);
    step("run8",         0, 0, 0, 0,            0, 0,     RV + 8,       1, 0, 0);
    step("flush_top",    0, 0, 1, 32'hFFFFFFF8, 0, 0,     32'hFFFFFFF8, 1, 0, 0);
    step("run_fffc",     0, 0, 0, 0,            0, 0,     32'hFFFFFFFC, 1, 0, 0);
    step("wrap",         0, 0, 0, 0,            0, 0,     32'h0,        1, 0, 0);
    step("flush_10",     0, 0, 1, 32'h10,       0, 0,     32'h10,       1, 0, 0);
    step("stall1",       0, 1, 0, 0,            0, 0,     32'h10,       1, 0, 0);
    step("stall2",       0, 1, 0, 0,            0, 0,     32'h10,       1, 0, 0);
    step("stall3",       0, 1, 0, 0,            0, 0,     32'h10,       1, 0, 0);
    step("unstall",      0, 0, 0, 0,            0, 0,     32'h14,       1, 0, 0);
    step("buf_200",      0, 1, 0, 0,            1, 32'h200, 32'h14,     1, 1, 0);
    step("buf_300",      0, 1, 0, 0,            1, 32'h300, 32'h14,     1, 1, 0);
    step("hold",         0, 1, 0, 0,            0, 0,     32'h14,       1, 1, 0);
    step("apply_300",    0, 0, 0, 0,            0, 0,     32'h300,      1, 0, 0);
    step("run_304",      0, 0, 0, 0,            0, 0,     32'h304,      1, 0, 0);
    step("flush_prio",   0, 1, 1, 32'h180,      1, 32'h40, 32'h180,     1, 0, 0);
    step("run_184",      0, 0, 0, 0,            0, 0,     32'h184,      1, 0, 0);
    step("br_misal",     0, 0, 0, 0,            1, 32'h103, 32'h100,    1, 0, 1);
    step("misal_pulse",  0, 0, 0, 0,            0, 0,     32'h104,      1, 0, 0);
    step("buf_2",        0, 1, 0, 0,            1, 32'h2, 32'h104,      1, 1, 0);
    step("live_beats",   0, 0, 0, 0,            1, 32'h500, 32'h500,    1, 0, 0);
    step("buf_206",      0, 1, 0, 0,            1, 32'h206, 32'h500,    1, 1, 0);
    step("apply_204",    0, 0, 0, 0,            0, 0,     32'h204,      1, 0, 1);
    step("run_208",      0, 0, 0, 0,            0, 0,     32'h208,      1, 0, 0);
    step("flush_misal",  0, 0, 1, 32'h3FE,      0, 0,     32'h3FC,      1, 0, 1);
    step("buf_600",      0, 1, 0, 0,            1, 32'h600, 32'h3FC,    1, 1, 0);
    step("rst_pending",  1, 1, 0, 0,            0, 0,     RV,           0, 0, 0);
    step("rerelease",    0, 0, 0, 0,            0, 0,     RV,           1, 0, 0);
    step("rerun4",       0, 0, 0, 0,            0, 0,     RV + 4,       1, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
